emu_run_ctrl: RTL and testbench
===============================

Name: emu_run_ctrl

Overview:
- Emulation run controller between the clock generator/host control probes and the testbench.
- Holds the testbench in reset until the clock wizard is locked and the host reset is released.
- Executes host run/stop/step/run-until commands by gating a clock-enable to the emulated design.
- Maintains the emulation time counter exported to the time probe.

Parameters:
TIME_WIDTH, 64, width of emulation time counter emu_time
STEP_WIDTH, 32, width of cmd_arg (step count / run-until target)
RST_HOLD_CYCLES, 16, consecutive qualified cycles required before leaving reset hold (>=1)

Ports:
clk  input  1  emulation clock; all logic on rising edge
rst_n  input  1  synchronous reset, active-low
locked  input  1  clock wizard locked
host_rst  input  1  host reset request (VIO), active-high
cmd_valid  input  1  command valid
cmd_ready  output  1  command ready; transfer when cmd_valid && cmd_ready
cmd_op  input  2  00 RUN, 01 STOP, 10 STEP, 11 RUN_UNTIL
cmd_arg  input  STEP_WIDTH  STEP count, or RUN_UNTIL target (zero-extended to TIME_WIDTH)
emu_rst  output  1  testbench reset, active-high
emu_ce  output  1  emulation clock-enable, registered
emu_time  output  TIME_WIDTH  count of cycles with emu_ce=1 since reset hold
state  output  3  0 HOLD, 1 IDLE, 2 RUNNING, 3 STEPPING
done  output  1  one-cycle completion pulse

Behaviour:
- Reset (rst_n=0 at edge): state=HOLD, emu_rst=1, emu_ce=0, emu_time=0, cmd_ready=0, done=0, hold counter=0, step remaining=0, target=0.
- All outputs are registered. A command accepted at edge k changes state, emu_ce, cmd_ready and done from cycle k+1.
- Abort: locked=0 or host_rst=1 in any state -> HOLD next cycle. In HOLD: emu_ce=0, emu_rst=1, emu_time=0, hold counter=0, no done pulse. Abort has priority over every command and completion.
- HOLD: cmd_ready=0. Hold counter increments each cycle with locked=1 && host_rst=0. When the count reaches RST_HOLD_CYCLES -> IDLE; emu_rst falls on IDLE entry.
- IDLE: cmd_ready=1, emu_ce=0.
  - RUN -> RUNNING.
  - STEP N, N=0 -> stay IDLE, done pulse.
  - STEP N, N>0 -> STEPPING, remaining=N.
  - RUN_UNTIL T, T<=emu_time (unsigned) -> stay IDLE, done pulse.
  - RUN_UNTIL T, T>emu_time -> RUNNING with target armed.
  - STOP -> stay IDLE, done pulse.
- RUNNING / STEPPING: cmd_ready=1, emu_ce=1.
  - STOP -> IDLE, emu_ce=0 next cycle, done pulse.
  - RUN, STEP and RUN_UNTIL are accepted and discarded: no state change, no done.
- emu_time increments by 1 on every edge where emu_ce=1, wrapping modulo 2^TIME_WIDTH.
- STEP N accepted at edge k: emu_ce=1 for exactly cycles k+1..k+N; at k+N+1 state=IDLE, done=1, emu_time=old+N.
- RUN_UNTIL T: emu_ce stops so that emu_time==T on the first IDLE cycle; done=1 in that cycle. The target disarms on STOP or abort.
- Plain RUN never self-terminates; wrap of emu_time does not stop it.
- Simultaneous STOP and natural completion (last step cycle / target reached): -> IDLE with a single done pulse, same counts as natural completion.
- done is never high for two consecutive cycles from the same command.
- rst_n=0 mid-operation: immediate return to the reset values above.

Test Plan:
- Power-up with locked=1, host_rst=0, RST_HOLD_CYCLES=16 -> emu_rst=1 for 16 cycles after reset release, state=IDLE and emu_rst=0 at cycle 17, cmd_ready=1.
- Lock glitch: locked=0 for 1 cycle at hold count 10 -> counter restarts; IDLE reached 16 qualified cycles after locked returns.
- STEP 5 from emu_time=0 -> emu_ce high exactly 5 cycles, then state=IDLE, done=1 for 1 cycle, emu_time=5.
- STEP 0 -> no emu_ce pulse, done=1 next cycle, emu_time unchanged.
- RUN_UNTIL 100 from emu_time=40 -> 60 emu_ce cycles, IDLE with emu_time=100 and done pulse.
- RUN_UNTIL 30 from emu_time=40 -> immediate done, no emu_ce.
- RUN, STOP after 7 cycles, STEP issued while running:
  - STEP is discarded.
  - emu_time=7 at IDLE, single done.
  - host_rst=1 while RUNNING -> HOLD next cycle, emu_ce=0, emu_time=0, no done.

Source files
------------

// File: rtl/emu_run_ctrl.sv
// Emulation run controller: holds the testbench in reset until the clock is locked, then
// gates a clock-enable according to host run/stop/step/run-until commands and counts emulated time.
module emu_run_ctrl #(
    parameter int TIME_WIDTH      = 64,
    parameter int STEP_WIDTH      = 32,
    parameter int RST_HOLD_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  locked,
    input  logic                  host_rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [STEP_WIDTH-1:0] cmd_arg,
    output logic                  emu_rst,
    output logic                  emu_ce,
    output logic [TIME_WIDTH-1:0] emu_time,
    output logic [2:0]            state,
    output logic                  done
);

    typedef enum logic [2:0] {
        S_HOLD     = 3'd0,
        S_IDLE     = 3'd1,
        S_RUNNING  = 3'd2,
        S_STEPPING = 3'd3
    } state_t;

    localparam logic [1:0] OP_RUN       = 2'b00;
    localparam logic [1:0] OP_STOP      = 2'b01;
    localparam logic [1:0] OP_STEP      = 2'b10;
    localparam logic [1:0] OP_RUN_UNTIL = 2'b11;

    localparam int HCW = (RST_HOLD_CYCLES > 1) ? $clog2(RST_HOLD_CYCLES) : 1;
    localparam logic [HCW-1:0] HOLD_LAST = HCW'(RST_HOLD_CYCLES - 1);

    state_t                state_q, state_n;
    logic [HCW-1:0]        hold_cnt, hold_cnt_n;
    logic [STEP_WIDTH-1:0] remaining, remaining_n;
    logic [TIME_WIDTH-1:0] target, target_n;
    logic                  armed, armed_n;
    logic [TIME_WIDTH-1:0] time_n;
    logic                  ce_n, done_n, emu_rst_n, ready_n;
    logic                  cmd_fire, abort;
    logic [TIME_WIDTH-1:0] arg_ext;

    // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready; cmd_ready is
    // registered and does not depend on cmd_valid, so the host may hold cmd_valid until it sees ready.
    assign cmd_fire = cmd_valid && cmd_ready;
    assign abort    = !locked || host_rst;
    assign arg_ext  = TIME_WIDTH'(cmd_arg);
    assign state    = state_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_HOLD;
            hold_cnt  <= '0;
            remaining <= '0;
            target    <= '0;
            armed     <= 1'b0;
            emu_time  <= '0;
            emu_ce    <= 1'b0;
            emu_rst   <= 1'b1;
            cmd_ready <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_n;
            hold_cnt  <= hold_cnt_n;
            remaining <= remaining_n;
            target    <= target_n;
            armed     <= armed_n;
            emu_time  <= time_n;
            emu_ce    <= ce_n;
            emu_rst   <= emu_rst_n;
            cmd_ready <= ready_n;
            done      <= done_n;
        end
    end

    always_comb begin
        state_n     = state_q;
        hold_cnt_n  = hold_cnt;
        remaining_n = remaining;
        target_n    = target;
        armed_n     = armed;
        time_n      = emu_time + TIME_WIDTH'(emu_ce);
        ce_n        = 1'b0;
        done_n      = 1'b0;

        if (abort) begin
            state_n     = S_HOLD;
            hold_cnt_n  = '0;
            remaining_n = '0;
            target_n    = '0;
            armed_n     = 1'b0;
            time_n      = '0;
        end else begin
            case (state_q)
                S_HOLD: begin
                    time_n = '0;
                    if (hold_cnt == HOLD_LAST) begin
                        state_n    = S_IDLE;
                        hold_cnt_n = '0;
                    end else begin
                        hold_cnt_n = hold_cnt + HCW'(1);
                    end
                end
                S_IDLE: begin
                    if (cmd_fire) begin
                        case (cmd_op)
                            OP_RUN: begin
                                state_n = S_RUNNING;
                                ce_n    = 1'b1;
                            end
                            OP_STOP: done_n = 1'b1;
                            OP_STEP: begin
                                if (cmd_arg == '0) begin
                                    done_n = 1'b1;
                                end else begin
                                    state_n     = S_STEPPING;
                                    remaining_n = cmd_arg;
                                    ce_n        = 1'b1;
                                end
                            end
                            OP_RUN_UNTIL: begin
                                if (arg_ext <= emu_time) begin
                                    done_n = 1'b1;
                                end else begin
                                    state_n  = S_RUNNING;
                                    target_n = arg_ext;
                                    armed_n  = 1'b1;
                                    ce_n     = 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                S_RUNNING: begin
                    ce_n = 1'b1;
                    // Stop on the edge that brings emu_time up to the target; a coincident STOP
                    // lands in the same branch set, so only one done pulse results.
                    if ((armed && (emu_time + TIME_WIDTH'(1) == target)) ||
                        (cmd_fire && cmd_op == OP_STOP)) begin
                        state_n  = S_IDLE;
                        ce_n     = 1'b0;
                        done_n   = 1'b1;
                        armed_n  = 1'b0;
                        target_n = '0;
                    end
                end
                S_STEPPING: begin
                    ce_n = 1'b1;
                    if ((remaining == STEP_WIDTH'(1)) || (cmd_fire && cmd_op == OP_STOP)) begin
                        state_n     = S_IDLE;
                        ce_n        = 1'b0;
                        done_n      = 1'b1;
                        remaining_n = '0;
                    end else begin
                        remaining_n = remaining - STEP_WIDTH'(1);
                    end
                end
                default: state_n = S_HOLD;
            endcase
        end

        emu_rst_n = (state_n == S_HOLD);
        ready_n   = (state_n != S_HOLD);
    end

endmodule

// File: tb/tb_emu_run_ctrl.sv
// Self-checking bench for emu_run_ctrl: directed scenarios plus randomized commands checked
// against a budget-based behavioural model of the run controller.
module tb_emu_run_ctrl;

    localparam int TW = 64;
    localparam int SW = 32;
    localparam int HOLD = 16;

    logic          clk = 1'b0;
    logic          rst_n, locked, host_rst, cmd_valid;
    logic          cmd_ready, emu_rst, emu_ce, done;
    logic [1:0]    cmd_op;
    logic [SW-1:0] cmd_arg;
    logic [TW-1:0] emu_time;
    logic [2:0]    state;
    logic [70:0]   dut_vec;

    int n_cmp  = 0;
    int n_fail = 0;

    // model: state 0 HOLD / 1 IDLE / 2 RUNNING / 3 STEPPING; budget = remaining enabled cycles, -1 = unlimited
    int            m_state;
    logic [63:0]   m_time;
    longint        m_budget;
    int            m_hold;
    bit            m_ce, m_done;
    logic [TW-1:0] exp_q[$];

    emu_run_ctrl #(.TIME_WIDTH(TW), .STEP_WIDTH(SW), .RST_HOLD_CYCLES(HOLD)) dut (
        .clk(clk), .rst_n(rst_n), .locked(locked), .host_rst(host_rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_arg(cmd_arg),
        .emu_rst(emu_rst), .emu_ce(emu_ce), .emu_time(emu_time), .state(state), .done(done)
    );

    assign dut_vec = {state, emu_ce, emu_rst, cmd_ready, done, emu_time};

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [70:0] exp_vec();
        return {m_state[2:0], m_ce, m_state == 0, m_state != 0, m_done, m_time};
    endfunction

    task automatic model_edge();
        bit fire;
        logic [63:0] t_next, arg_ext;
        fire    = cmd_valid && (m_state != 0);
        arg_ext = {32'd0, cmd_arg};
        t_next  = m_time + {63'd0, m_ce};
        m_done  = 1'b0;
        if (!rst_n || !locked || host_rst) begin
            m_state = 0; m_time = '0; m_budget = 0; m_hold = 0; m_ce = 1'b0;
        end else begin
            case (m_state)
                0: begin
                    m_hold++;
                    if (m_hold == HOLD) begin m_state = 1; m_hold = 0; end
                end
                1: if (fire) begin
                    case (cmd_op)
                        2'b00: begin m_budget = -1; m_state = 2; end
                        2'b01: m_done = 1'b1;
                        2'b10: if (cmd_arg == 0) m_done = 1'b1;
                               else begin m_budget = longint'(arg_ext); m_state = 3; end
                        default: if (arg_ext <= m_time) m_done = 1'b1;
                                 else begin m_budget = longint'(arg_ext - m_time); m_state = 2; end
                    endcase
                end
                default: begin
                    if (m_budget > 0) begin
                        m_budget--;
                        if (m_budget == 0) begin m_state = 1; m_done = 1'b1; end
                    end
                    if (m_state != 1 && fire && cmd_op == 2'b01) begin
                        m_state = 1; m_done = 1'b1; m_budget = 0;
                    end
                end
            endcase
            m_ce   = (m_state == 2 || m_state == 3);
            m_time = (m_state == 0) ? 64'd0 : t_next;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [SW-1:0] arg);
        cmd_valid = 1'b1; cmd_op = op; cmd_arg = arg;
        cycle();
        cmd_valid = 1'b0;
    endtask

    task automatic bring_up();
        rst_n = 1'b0; locked = 1'b1; host_rst = 1'b0; cmd_valid = 1'b0;
        cycle();
        rst_n = 1'b1;
        repeat (HOLD) cycle();
    endtask

    // counts enabled cycles from the current sample until done is seen (bounded)
    task automatic wait_done(output int ce_cnt, output bit ok);
        ce_cnt = 0; ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (emu_ce) ce_cnt++;
            if (done) begin ok = 1'b1; break; end
            cycle();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; locked = 1'b1; host_rst = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_arg = '0;
        repeat (3) cycle();
        n_cmp++;
        if (dut_vec !== {3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 64'd0}) begin
            n_fail++; $display("FAIL reset: got %h exp %h", dut_vec, {3'd0, 4'b0100, 64'd0});
        end
    endtask

    task automatic test_power_up();
        rst_n = 1'b1;
        for (int i = 1; i <= HOLD; i++) begin
            cycle();
            n_cmp++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL power_up cyc %0d: got %h exp %h", i, dut_vec, exp_vec());
            end
        end
        n_cmp++;
        if (state !== 3'd1 || emu_rst !== 1'b0 || cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL power_up_idle: state %0d rst %b ready %b exp 1 0 1", state, emu_rst, cmd_ready);
        end
    endtask

    task automatic test_lock_glitch();
        int cnt;
        rst_n = 1'b0; cycle(); rst_n = 1'b1;
        repeat (10) cycle();
        locked = 1'b0; cycle(); locked = 1'b1;
        n_cmp++;
        if (state !== 3'd0 || emu_rst !== 1'b1) begin
            n_fail++; $display("FAIL glitch_hold: state %0d rst %b exp 0 1", state, emu_rst);
        end
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            cycle(); cnt++;
            if (state == 3'd1) break;
        end
        n_cmp++;
        if (cnt != HOLD || state !== 3'd1) begin
            n_fail++; $display("FAIL glitch_restart: idle after %0d cycles exp %0d", cnt, HOLD);
        end
    endtask

    task automatic test_step();
        int ce_cnt; bit ok;
        issue(2'b10, 32'd5);
        wait_done(ce_cnt, ok);
        n_cmp++;
        if (!ok || ce_cnt != 5 || emu_time !== 64'd5 || state !== 3'd1) begin
            n_fail++; $display("FAIL step5: ok %b ce %0d time %0d state %0d exp 1 5 5 1", ok, ce_cnt, emu_time, state);
        end
        cycle();
        n_cmp++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL step5_single_done: done %b exp 0", done); end
        issue(2'b10, 32'd0);
        n_cmp++;
        if (done !== 1'b1 || emu_ce !== 1'b0 || emu_time !== 64'd5) begin
            n_fail++; $display("FAIL step0: done %b ce %b time %0d exp 1 0 5", done, emu_ce, emu_time);
        end
    endtask

    task automatic test_run_until();
        int ce_cnt; bit ok;
        issue(2'b10, 32'd35);
        wait_done(ce_cnt, ok);
        cycle();
        issue(2'b11, 32'd100);
        wait_done(ce_cnt, ok);
        n_cmp++;
        if (!ok || ce_cnt != 60 || emu_time !== 64'd100 || state !== 3'd1) begin
            n_fail++; $display("FAIL until100: ok %b ce %0d time %0d state %0d exp 1 60 100 1", ok, ce_cnt, emu_time, state);
        end
        cycle();
        issue(2'b11, 32'd30);
        n_cmp++;
        if (done !== 1'b1 || emu_ce !== 1'b0 || emu_time !== 64'd100 || state !== 3'd1) begin
            n_fail++; $display("FAIL until_past: done %b ce %b time %0d state %0d exp 1 0 100 1", done, emu_ce, emu_time, state);
        end
    endtask

    task automatic test_run_stop();
        bring_up();
        issue(2'b00, 32'd0);
        repeat (2) cycle();
        issue(2'b10, 32'd4);
        n_cmp++;
        if (state !== 3'd2 || done !== 1'b0 || emu_ce !== 1'b1) begin
            n_fail++; $display("FAIL step_discard: state %0d done %b ce %b exp 2 0 1", state, done, emu_ce);
        end
        repeat (3) cycle();
        issue(2'b01, 32'd0);
        n_cmp++;
        if (state !== 3'd1 || done !== 1'b1 || emu_ce !== 1'b0 || emu_time !== 64'd7) begin
            n_fail++; $display("FAIL run_stop: state %0d done %b ce %b time %0d exp 1 1 0 7", state, done, emu_ce, emu_time);
        end
        cycle();
        n_cmp++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL stop_single_done: done %b exp 0", done); end
        issue(2'b00, 32'd0);
        repeat (2) cycle();
        host_rst = 1'b1; cycle(); host_rst = 1'b0;
        n_cmp++;
        if (dut_vec !== {3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 64'd0}) begin
            n_fail++; $display("FAIL host_abort: got %h exp %h", dut_vec, {3'd0, 4'b0100, 64'd0});
        end
    endtask

    task automatic test_stop_at_completion();
        bring_up();
        issue(2'b10, 32'd3);
        repeat (2) cycle();
        issue(2'b01, 32'd0);
        n_cmp++;
        if (state !== 3'd1 || done !== 1'b1 || emu_time !== 64'd3 || dut_vec !== exp_vec()) begin
            n_fail++; $display("FAIL stop_at_last_step: got %h exp %h", dut_vec, exp_vec());
        end
        cycle();
        n_cmp++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL stop_at_last_step_done: done %b exp 0", done); end
    endtask

    task automatic test_random();
        logic [TW-1:0] e;
        for (int i = 0; i < 3000; i++) begin
            cmd_valid = ($urandom_range(0, 1) == 1);
            cmd_op    = 2'($urandom_range(0, 3));
            if (cmd_op == 2'b11)
                cmd_arg = m_time[31:0] + 32'($urandom_range(0, 40)) - 32'd10;
            else
                cmd_arg = 32'($urandom_range(0, 20));
            locked   = ($urandom_range(0, 199) != 0);
            host_rst = ($urandom_range(0, 299) == 0);
            rst_n    = ($urandom_range(0, 499) != 0);
            cycle();
            if (m_done) exp_q.push_back(m_time);
            n_cmp++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL random cyc %0d: got %h exp %h", i, dut_vec, exp_vec());
            end
            if (done) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
                n_cmp++;
                if (emu_time !== e) begin
                    n_fail++; $display("FAIL random_done_time cyc %0d: got %0d exp %0d", i, emu_time, e);
                end
            end
        end
        cmd_valid = 1'b0; locked = 1'b1; host_rst = 1'b0; rst_n = 1'b1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL random_done_missing: %0d pending exp 0", exp_q.size());
        end
    endtask

    initial begin
        m_state = 0; m_time = '0; m_budget = 0; m_hold = 0; m_ce = 1'b0; m_done = 1'b0;
        test_reset();
        test_power_up();
        test_lock_glitch();
        test_step();
        test_run_until();
        test_run_stop();
        test_stop_at_completion();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
